// File: rtl/simple_mem_pkg.sv
// Shared constants and types for the simple_mem register-file memory.
package simple_mem_pkg;

  localparam int unsigned ADDR_WIDTH = 2;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam data_t RESET_VAL = DATA_WIDTH'(8'hFF);

endpackage : simple_mem_pkg

// File: rtl/simple_mem_array.sv
// Storage array for simple_mem: write port plus combinational read of current contents.
module simple_mem_array
  import simple_mem_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  we_i,
  input  addr_t addr_i,
  input  data_t wdata_i,
  output data_t rd_data_c_o
);

  data_t mem_q [DEPTH];
  data_t mem_d [DEPTH];

  // Next-state contents: only the addressed word changes on a write.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we_i) begin
      mem_d[addr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Reads see pre-edge contents, giving read-before-write on a shared address.
  assign rd_data_c_o = mem_q[addr_i];

endmodule : simple_mem_array

// File: rtl/simple_mem.sv
// Single-port register-file memory with independent write/read enables and registered read data.
module simple_mem
  import simple_mem_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  addr_t addr,
  input  logic  wr_en,
  input  logic  rd_en,
  input  data_t wdata,
  output data_t rdata
);

  data_t rd_data_c;
  data_t rdata_q;
  data_t rdata_d;

  simple_mem_array u_array (
    .clk         (clk),
    .reset       (reset),
    .we_i        (wr_en),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rd_data_c_o (rd_data_c)
  );

  // Read data holds its last value when no read is issued.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = rd_data_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule : simple_mem

// File: tb/tb_simple_mem.sv
// Directed and randomised checks of simple_mem against hand-computed values and a 4-entry model.
module tb_simple_mem;
  import simple_mem_pkg::*;

  logic  clk;
  logic  reset;
  addr_t addr;
  logic  wr_en;
  logic  rd_en;
  data_t wdata;
  data_t rdata;

  int checks;
  int errors;

  simple_mem dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .wdata (wdata),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one command, clock it, and leave time 1 ns after the edge for sampling.
  task automatic op(input logic w, input logic r, input addr_t a, input data_t d);
    wr_en = w;
    rd_en = r;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr  = '0;
    wdata = '0;
    #6;
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata got %h exp %h", rdata, 8'h00);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op(1'b0, 1'b1, addr_t'(i), 8'h00);
      checks++;
      if (rdata !== 8'hFF) begin
        errors++;
        $display("FAIL default_read addr %0d got %h exp %h", i, rdata, 8'hFF);
      end
    end
  endtask

  task automatic test_write_read();
    op(1'b1, 1'b0, 2'd2, 8'hA5);
    op(1'b0, 1'b1, 2'd2, 8'h00);
    checks++;
    if (rdata !== 8'hA5) begin
      errors++;
      $display("FAIL write_read addr 2 got %h exp %h", rdata, 8'hA5);
    end
    for (int i = 0; i < 4; i++) begin
      if (i != 2) begin
        op(1'b0, 1'b1, addr_t'(i), 8'h00);
        checks++;
        if (rdata !== 8'hFF) begin
          errors++;
          $display("FAIL untouched addr %0d got %h exp %h", i, rdata, 8'hFF);
        end
      end
    end
  endtask

  task automatic test_simul_rw();
    op(1'b1, 1'b0, 2'd1, 8'h3C);
    op(1'b1, 1'b1, 2'd1, 8'h77);
    checks++;
    if (rdata !== 8'h3C) begin
      errors++;
      $display("FAIL read_before_write got %h exp %h", rdata, 8'h3C);
    end
    op(1'b0, 1'b1, 2'd1, 8'h00);
    checks++;
    if (rdata !== 8'h77) begin
      errors++;
      $display("FAIL after_rbw got %h exp %h", rdata, 8'h77);
    end
  endtask

  task automatic test_hold();
    op(1'b0, 1'b1, 2'd2, 8'h00);
    checks++;
    if (rdata !== 8'hA5) begin
      errors++;
      $display("FAIL hold_setup got %h exp %h", rdata, 8'hA5);
    end
    for (int i = 0; i < 3; i++) begin
      op(1'b1, 1'b0, 2'd2, 8'h11);
      checks++;
      if (rdata !== 8'hA5) begin
        errors++;
        $display("FAIL hold cycle %0d got %h exp %h", i, rdata, 8'hA5);
      end
    end
    op(1'b0, 1'b1, 2'd2, 8'h00);
    checks++;
    if (rdata !== 8'h11) begin
      errors++;
      $display("FAIL hold_after_write got %h exp %h", rdata, 8'h11);
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 4; i++) begin
      op(1'b1, 1'b0, addr_t'(i), 8'h5A);
    end
    op(1'b0, 1'b1, 2'd3, 8'h00);
    checks++;
    if (rdata !== 8'h5A) begin
      errors++;
      $display("FAIL pre_reset_read got %h exp %h", rdata, 8'h5A);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_rdata got %h exp %h", rdata, 8'h00);
    end
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      op(1'b0, 1'b1, addr_t'(i), 8'h00);
      checks++;
      if (rdata !== 8'hFF) begin
        errors++;
        $display("FAIL post_reset addr %0d got %h exp %h", i, rdata, 8'hFF);
      end
    end
  endtask

  task automatic test_random();
    data_t model [4];
    data_t exp_rdata;
    logic  w;
    logic  r;
    addr_t a;
    data_t d;
    for (int i = 0; i < 4; i++) model[i] = 8'hFF;
    exp_rdata = 8'hFF;
    for (int n = 0; n < 200; n++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      a = addr_t'($urandom_range(0, 3));
      d = data_t'($urandom_range(0, 255));
      if (r) exp_rdata = model[a];
      if (w) model[a] = d;
      op(w, r, a, d);
      checks++;
      if (rdata !== exp_rdata) begin
        errors++;
        $display("FAIL random op %0d wr %0b rd %0b addr %0d got %h exp %h",
                 n, w, r, a, rdata, exp_rdata);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_simul_rw();
    test_hold();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_simple_mem

// File: doc/simple_mem.md
Name: simple_mem

Overview:
Small synchronous single-port register-file memory with independent write and read enables, one address bus, and a registered read-data output. It sits behind the mem_intf bus interface as the storage target for write/read traffic. All locations initialise to a known default value on reset, so reads of never-written addresses are deterministic.

Parameters:
ADDR_WIDTH, 2, address width; depth = 2**ADDR_WIDTH (4 locations)
DATA_WIDTH, 8, width of every stored word and of wdata/rdata
RESET_VAL, 8'hFF, value loaded into every location on reset (DATA_WIDTH bits)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
addr  input  ADDR_WIDTH  word address for the write or read
wr_en  input  1  write enable; sampled on rising clk
rd_en  input  1  read enable; sampled on rising clk
wdata  input  DATA_WIDTH  write data
rdata  output  DATA_WIDTH  registered read data

Behaviour:
- Reset (reset==0, asynchronous, no clock required): every location = RESET_VAL; rdata = 0. Held while reset is low; wr_en/rd_en ignored.
- Reset release is synchronised by the flop structure only; the first active edge after reset goes high may carry a command.
- Write: rising clk with wr_en==1 -> mem[addr] <= wdata. Visible to a read issued on the following edge or later.
- Read: rising clk with rd_en==1 -> rdata <= mem[addr]. Latency 1 cycle: data valid after the edge that sampled rd_en.
- rd_en==0: rdata holds its last value (no return to 0, no X).
- wr_en==1 and rd_en==1 on the same edge: both performed. For the same address, the read returns the OLD contents (read-before-write). The new data is readable on the next read.
- Neither enable set: no state change.
- Address is full-range; all 2**ADDR_WIDTH values are legal, with no wrap or out-of-range case. Do not infer byte enables.
- Reset asserted mid-operation: any write on that edge is discarded; all locations revert to RESET_VAL; rdata -> 0.
- No X propagation from unwritten locations, because reset initialises all storage.

Decomposition:
- Package simple_mem_pkg: ADDR_WIDTH, DATA_WIDTH, DEPTH, RESET_VAL constants; typedefs addr_t and data_t.
- No sub-module required. An optional simple_mem_array leaf holds storage plus reset init. The top then holds only the rdata register.

Test Plan:
- Default read: assert reset low for 5 ns, then release. Read addr 0..3 -> rdata = 8'hFF for each, one cycle after each rd_en.
- Write then read: write 8'hA5 to addr 2, then read addr 2 on the next cycle -> rdata = 8'hA5. Reads of addr 0/1/3 still return 8'hFF.
- Simultaneous read/write: mem[1]=8'h3C, then wr_en=rd_en=1 at addr 1 with wdata=8'h77 -> rdata = 8'h3C. The next read of addr 1 returns 8'h77.
- Hold: read addr 2 (8'hA5), then drop rd_en for 3 cycles while writing 8'h11 to addr 2 -> rdata stays 8'hA5 throughout.
- Reset mid-run: write 8'h5A to all addresses, then pulse reset low between clock edges -> rdata = 0 immediately. Subsequent reads of all addresses return 8'hFF.
- Random: 200 random wr/rd ops against a 4-entry reference model -> every read matches, including same-address read-before-write.
